// File: rtl/score_accum.sv
// Score accumulator for the four-digit score display: sums gameplay event points with
// saturation, tracks game phase and flags extra-life thresholds. Optional high-score
// tracking is built when SCORE_HISCORE_EN is defined.
module score_accum #(
    parameter logic [9:0] SCORE_MAX = 10'd1023,
    parameter logic [9:0] LIFE_STEP = 10'd500,
    parameter logic [9:0] ROCK_PTS  = 10'd100
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       game_start,
    input  logic       game_over,
    input  logic       dig_evt,
    input  logic       kill_evt,
    input  logic [1:0] kill_depth,
    input  logic       rock_evt,
    output logic [9:0] dig_sum,
    output logic       playing,
    output logic       extra_life,
    output logic [9:0] hi_score,
    output logic       new_hi
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [9:0]  dig_sum_r;
    logic [9:0]  score_nxt_s;
    logic        playing_r;
    logic        extra_life_r;
    logic        life_nxt_s;
    logic        accept_s;
    logic [10:0] inc_s;
    logic [9:0]  sat_sum_s;

    // Points for an enemy kill, scaled by the depth it was killed at.
    function automatic logic [10:0] kill_pts(input logic [1:0] depth);
        logic [10:0] pts;
        case (depth)
            2'b00:   pts = 11'd10;
            2'b01:   pts = 11'd20;
            2'b10:   pts = 11'd30;
            2'b11:   pts = 11'd40;
            default: pts = 11'd0;
        endcase
        return pts;
    endfunction

    // Widened add clamped to the ceiling, so the score can never wrap.
    function automatic logic [9:0] sat_add(input logic [9:0] base, input logic [10:0] inc,
                                           input logic [9:0] ceil);
        logic [10:0] sum;
        logic [9:0]  res;
        sum = {1'b0, base} + inc;
        if (sum > {1'b0, ceil}) begin
            res = ceil;
        end else begin
            res = sum[9:0];
        end
        return res;
    endfunction

    // True when an update moves the score from below a threshold to at/above it.
    function automatic logic crosses(input logic [9:0] old_v, input logic [9:0] new_v,
                                     input logic [10:0] thr);
        return ({1'b0, old_v} < thr) && ({1'b0, new_v} >= thr);
    endfunction

    // Per-cycle increment from all simultaneous event pulses.
    always_comb begin
        inc_s = {10'd0, dig_evt};
        if (kill_evt) begin
            inc_s = inc_s + kill_pts(kill_depth);
        end else begin
            inc_s = inc_s + 11'd0;
        end
        if (rock_evt) begin
            inc_s = inc_s + {1'b0, ROCK_PTS};
        end else begin
            inc_s = inc_s + 11'd0;
        end
    end

    assign accept_s  = (state_r == ST_PLAY) && !game_start;
    assign sat_sum_s = sat_add(dig_sum_r, inc_s, SCORE_MAX);

    // Next state, next score and extra-life detection.
    always_comb begin
        state_nxt_s = state_r;
        score_nxt_s = dig_sum_r;
        life_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (game_start) begin
                    state_nxt_s = ST_PLAY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (game_start) begin
                    state_nxt_s = ST_PLAY;
                end else if (game_over) begin
                    state_nxt_s = ST_FROZEN;
                end else begin
                    state_nxt_s = ST_PLAY;
                end
            end
            ST_FROZEN: begin
                if (game_start) begin
                    state_nxt_s = ST_PLAY;
                end else begin
                    state_nxt_s = ST_FROZEN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase

        if (game_start) begin
            score_nxt_s = 10'd0;
        end else if (accept_s) begin
            score_nxt_s = sat_sum_s;
            // A single update spans at most 141 points, so only one threshold can be crossed.
            life_nxt_s  = crosses(dig_sum_r, sat_sum_s, {1'b0, LIFE_STEP}) ||
                          crosses(dig_sum_r, sat_sum_s, {LIFE_STEP, 1'b0});
        end else begin
            score_nxt_s = dig_sum_r;
        end
    end

    // State, score and pulse registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r      <= ST_IDLE;
            dig_sum_r    <= 10'd0;
            playing_r    <= 1'b0;
            extra_life_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            dig_sum_r    <= score_nxt_s;
            playing_r    <= (state_nxt_s == ST_PLAY);
            extra_life_r <= life_nxt_s;
        end
    end

    assign dig_sum    = dig_sum_r;
    assign playing    = playing_r;
    assign extra_life = extra_life_r;

`ifdef SCORE_HISCORE_EN
    logic [9:0] hi_score_r;
    logic       new_hi_r;
    logic       freeze_s;

    assign freeze_s = (state_r == ST_PLAY) && !game_start && game_over;

    // High score is captured on the freeze edge using the score that includes same-cycle events.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hi_score_r <= 10'd0;
            new_hi_r   <= 1'b0;
        end else if (game_start) begin
            hi_score_r <= hi_score_r;
            new_hi_r   <= 1'b0;
        end else if (freeze_s && (sat_sum_s > hi_score_r)) begin
            hi_score_r <= sat_sum_s;
            new_hi_r   <= 1'b1;
        end else begin
            hi_score_r <= hi_score_r;
            new_hi_r   <= new_hi_r;
        end
    end

    assign hi_score = hi_score_r;
    assign new_hi   = new_hi_r;
`else
    assign hi_score = 10'd0;
    assign new_hi   = 1'b0;
`endif

endmodule
